// File: rtl/cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_responder
// Purpose  : Memory-side responder for a cache line interface. It accepts one
//            line request at a time, waits a fixed number of cycles, then
//            either absorbs a write-back burst into a word-addressed backing
//            store or streams a line back to the cache as a load burst.
//            Line addresses wrap modulo the backing-store depth.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_responder #(
  parameter int ADDR_SIZE      = 32,
  parameter int DATA_SIZE      = 32,
  parameter int BLOCK_SIZE     = 6,
  parameter int WR_M_DATA_SIZE = 4,
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int LATENCY        = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          addr_valid_in,
  input  logic [ADDR_SIZE-1:0]                          addr_in,
  input  logic                                          rw_in,
  output logic                                          addr_ready,
  input  logic                                          valid_wb,
  input  logic [WR_M_DATA_SIZE-1:0][DATA_SIZE-1:0]      data_in_wb,
  output logic                                          ready_wb,
  output logic                                          valid_ld,
  output logic [WR_M_DATA_SIZE-1:0][DATA_SIZE-1:0]      data_out_ld,
  input  logic                                          ready_ld,
  output logic                                          busy
);

  // --------------------------------------------------------------------------
  // Derived geometry
  // --------------------------------------------------------------------------
  localparam int BYTES_PER_WORD = DATA_SIZE / 8;
  localparam int BYTE_SHIFT     = $clog2(BYTES_PER_WORD);
  localparam int BEATS          = (2 ** BLOCK_SIZE) / BYTES_PER_WORD / WR_M_DATA_SIZE;
  // One spare bit so the counter can reach BEATS without wrapping.
  localparam int BEAT_W         = $clog2(BEATS) + 1;
  localparam int AW             = MEM_WORDS_LOG2;
  localparam int DEPTH          = 2 ** MEM_WORDS_LOG2;

  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [3:0]           LAT_LAST  = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);
  localparam logic [ADDR_SIZE-1:0] LINE_MASK = {{(ADDR_SIZE-BLOCK_SIZE){1'b1}}, {BLOCK_SIZE{1'b0}}};

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LAT  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_LD   = 2'd3;

  logic [1:0]                                  state;
  logic                                        rw_q;
  logic [AW-1:0]                               base_word;
  logic [BEAT_W-1:0]                           beat;
  logic [3:0]                                  lat_cnt;

  // Backing store: deliberately not reset, contents undefined until written.
  logic [DATA_SIZE-1:0]                        mem [DEPTH];

  logic [AW-1:0]                               req_base_word;
  logic [AW-1:0]                               ld_base;
  logic [BEAT_W-1:0]                           ld_beat;
  logic [WR_M_DATA_SIZE-1:0][DATA_SIZE-1:0]    ld_next;
  logic                                        wb_fire;
  logic                                        ld_fire;
  logic                                        ld_last;

  // Word index of a beat element; truncation to AW bits gives the wrap.
  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0]     base,
                                              input logic [BEAT_W-1:0] b,
                                              input int                k);
    word_addr = base + AW'(b) * AW'(WR_M_DATA_SIZE) + AW'(k);
  endfunction

  // Line base of the incoming request, expressed as a word index.
  assign req_base_word = AW'((addr_in & LINE_MASK) >> BYTE_SHIFT);

  assign addr_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign ready_wb   = (state == ST_WB);
  assign valid_ld   = (state == ST_LD);

  assign wb_fire    = (state == ST_WB) && valid_wb;
  assign ld_fire    = (state == ST_LD) && ready_ld;
  assign ld_last    = (beat == LAST_BEAT);

  // Select the beat to fetch next: beat 0 when entering LD (straight from
  // IDLE when there is no latency, so the base comes from the live request),
  // otherwise the beat following the one being handed over.
  always_comb begin
    ld_base = (state == ST_IDLE) ? req_base_word : base_word;
    ld_beat = (state == ST_LD) ? (beat + 1'b1) : '0;
    ld_next = '0;
    for (int k = 0; k < WR_M_DATA_SIZE; k++) begin
      ld_next[k] = mem[word_addr(ld_base, ld_beat, k)];
    end
  end

  // Commit a write-back beat into the store; reset forces IDLE so an
  // interrupted burst stops writing immediately.
  always_ff @(posedge clk) begin
    if (wb_fire) begin
      for (int k = 0; k < WR_M_DATA_SIZE; k++) begin
        mem[word_addr(base_word, beat, k)] <= data_in_wb[k];
      end
    end
  end

  // Transaction sequencing: accept, latency wait, then burst transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rw_q        <= 1'b0;
      base_word   <= '0;
      beat        <= '0;
      lat_cnt     <= '0;
      data_out_ld <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (addr_valid_in) begin
            base_word <= req_base_word;
            rw_q      <= rw_in;
            beat      <= '0;
            lat_cnt   <= '0;
            if (LATENCY == 0) begin
              if (rw_in) begin
                state <= ST_WB;
              end else begin
                state       <= ST_LD;
                data_out_ld <= ld_next;
              end
            end else begin
              state <= ST_LAT;
            end
          end
        end

        ST_LAT: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            if (rw_q) begin
              state <= ST_WB;
            end else begin
              state       <= ST_LD;
              data_out_ld <= ld_next;
            end
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end

        ST_WB: begin
          if (valid_wb) begin
            beat <= beat + 1'b1;
            if (ld_last) begin
              state <= ST_IDLE;
            end
          end
        end

        ST_LD: begin
          if (ld_fire) begin
            beat <= beat + 1'b1;
            if (ld_last) begin
              state <= ST_IDLE;
            end else begin
              data_out_ld <= ld_next;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32: request address width.
REQ-002 SHALL have parameter DATA_SIZE, default 32: word width in bits.
REQ-003 SHALL have parameter BLOCK_SIZE, default 6: log2 of line size in bytes.
REQ-004 SHALL have parameter WR_M_DATA_SIZE, default 4: words per beat.
REQ-005 SHALL have parameter MEM_WORDS_LOG2, default 10: log2 of backing-store depth in words.
REQ-006 SHALL have parameter LATENCY, default 2: wait cycles between request accept and first beat, 0..15.
REQ-007 SHALL have one clock; reset is asynchronous and active-high.
REQ-008 SHALL have port clk, input, 1: rising-edge clock.
REQ-009 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-010 SHALL have port addr_valid_in, input, 1: cache request valid.
REQ-011 SHALL have port addr_in, input, ADDR_SIZE: request byte address.
REQ-012 SHALL have port rw_in, input, 1: 1 = write-back, 0 = line load.
REQ-013 SHALL have port addr_ready, output, 1: request can be accepted.
REQ-014 SHALL have port valid_wb, input, 1: write-back beat valid.
REQ-015 SHALL have port data_in_wb, input, WR_M_DATA_SIZE x DATA_SIZE: write-back beat; element 0 is the lowest-addressed word.
REQ-016 SHALL have port ready_wb, output, 1: write-back beat accepted when high with valid_wb.
REQ-017 SHALL have port valid_ld, output, 1: load beat valid.
REQ-018 SHALL have port data_out_ld, output, WR_M_DATA_SIZE x DATA_SIZE: load beat; element 0 is the lowest-addressed word.
REQ-019 SHALL have port ready_ld, input, 1: cache accepts load beat.
REQ-020 SHALL have port busy, output, 1: transaction in progress.

Function
REQ-021 SHALL define BEATS = 2^BLOCK_SIZE / (DATA_SIZE/8) / WR_M_DATA_SIZE, which is 4 at defaults.
REQ-022 SHALL use FSM states IDLE, LAT, WB and LD.
REQ-023 SHALL drive addr_ready = (state==IDLE) and busy = (state!=IDLE).
REQ-024 SHALL, in IDLE on addr_valid_in, capture line base = addr_in with the low BLOCK_SIZE bits cleared, capture rw_in, clear the beat counter, and go to LAT; LATENCY=0 goes directly to WB or LD.
REQ-025 SHALL count LATENCY cycles in LAT, then enter WB if rw=1, else LD.
REQ-026 SHALL make the first beat visible exactly LATENCY+1 cycles after the accepting edge.
REQ-027 SHALL ignore addr_valid_in outside IDLE; no queuing.
REQ-028 SHALL hold ready_wb high throughout WB.
REQ-029 SHALL, on each WB edge with valid_wb high, write data_in_wb[k] to word (line_base/4 + beat*WR_M_DATA_SIZE + k) mod 2^MEM_WORDS_LOG2 and increment beat.
REQ-030 SHALL return to IDLE after the handshake on beat BEATS-1.
REQ-031 SHALL hold valid_ld high throughout LD.
REQ-032 SHALL register data_out_ld from the store: beat 0 is loaded on LD entry; beat n+1 is loaded on the handshake of beat n.
REQ-033 SHALL hold data_out_ld stable while valid_ld && !ready_ld.
REQ-034 SHALL return to IDLE after the handshake on beat BEATS-1 and deassert valid_ld in the next cycle.
REQ-035 SHALL use the same address-wrap rule for loads as for write-backs: out-of-range addresses wrap modulo depth.
REQ-036 SHALL allow a new request in the cycle after returning to IDLE; minimum back-to-back gap is 1 IDLE cycle.
REQ-037 SHALL ignore valid_wb outside WB and ready_ld outside LD.
REQ-038 SHALL keep the beat counter at ceil(log2(BEATS))+1 bits; the counter never wraps within a transaction.

Reset
REQ-039 SHALL, on rst assertion, immediately drive state=IDLE, addr_ready=1 (once rst deasserts), ready_wb=0, valid_ld=0, data_out_ld=0, busy=0, and zero the beat and latency counters.
REQ-040 SHALL abandon a transaction on mid-burst reset; beats already written persist; no further writes occur.
REQ-041 SHALL NOT reset backing-store contents; they are undefined until written.

Verification
REQ-042 SHALL cover a write-back to 0x0000_0040, LATENCY=2, valid_wb always high, beats {i*4+k}: ready_wb rises 3 cycles after accept, 4 beats accepted on 4 consecutive edges, then addr_ready=1.
REQ-043 SHALL cover a load from 0x0000_0040 after the REQ-042 write-back, ready_ld always high: valid_ld is high for 4 cycles and beat n presents words {4n..4n+3}.
REQ-044 SHALL cover load backpressure, with ready_ld low for 3 cycles on beat 1: data_out_ld holds beat 1 unchanged, and beat 2 follows the first ready_ld high.
REQ-045 SHALL cover a request with addr_in=0x0000_0075 and a request with an address at/beyond the store depth: low 6 bits are ignored, and the address wraps to (addr/4) mod 1024.
REQ-046 SHALL cover rst pulsed after write-back beat 1: outputs return to reset values at once, a subsequent load of that line returns beats 0-1 new, and no further beats are written.
REQ-047 SHALL cover addr_valid_in held high during LD: it is ignored, and a new request is accepted on the first IDLE cycle with LATENCY=0, giving a first beat 1 cycle later.
